// File: rtl/scoreboard_display.sv
// Game-clock scoreboard: samples min/sec/period, converts them to BCD with a
// sequential double-dabble engine, scans five digits and drives a horn pulse.
module scoreboard_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int HORN_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] min,
  input  logic [10:0] sec,
  input  logic [10:0] period,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [4:0]  an,
  output logic        horn
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HORN_W = $clog2(HORN_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HORN_W-1:0] HORN_LOAD = HORN_W'(HORN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] clamp7(input logic [10:0] v, input logic [6:0] lim);
    return (v > {4'd0, lim}) ? lim : v[6:0];
  endfunction

  // One shift/add-3 step: tens in [14:11], ones in [10:7], binary in [6:0].
  function automatic logic [14:0] dabble_step(input logic [14:0] s);
    logic [14:0] t;
    t = s;
    if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic              first_r;
  logic [32:0]       in_q_r, in_prev_r;
  logic [20:0]       clamp_s, snap_r;
  state_t            state_r, state_s;
  logic              load_s, step_s, commit_s;
  logic [1:0]        phase_r;
  logic [2:0]        bit_r;
  logic [14:0]       sh_r, src_s, step_out_s;
  logic [6:0]        field_s;
  logic [7:0]        res_min_r, res_sec_r;
  logic [3:0]        res_per_r;
  logic [4:0][3:0]   dig_r;
  logic [SCAN_W-1:0] scan_cnt_r;
  logic [2:0]        idx_r;
  logic [3:0]        cur_dig_s;
  logic [HORN_W-1:0] horn_cnt_r;
  logic              horn_r, trig_s;

  // Input stage; the first edge after reset primes both copies identically.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_r   <= 1'b1;
      in_q_r    <= 33'd0;
      in_prev_r <= 33'd0;
    end else begin
      first_r   <= 1'b0;
      in_q_r    <= {min, sec, period};
      in_prev_r <= first_r ? {min, sec, period} : in_q_r;
    end
  end

  assign clamp_s = {clamp7(in_q_r[32:22], 7'd99), clamp7(in_q_r[21:11], 7'd99),
                    clamp7(in_q_r[10:0], 7'd9)};

  // Converter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Converter next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (clamp_s != snap_r) state_s = S_CONV; else state_s = S_IDLE;
      S_CONV:   if ((bit_r == 3'd6) && (phase_r == 2'd2)) state_s = S_COMMIT; else state_s = S_CONV;
      S_COMMIT: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Converter control outputs.
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      S_IDLE:   load_s   = (clamp_s != snap_r);
      S_CONV:   step_s   = 1'b1;
      S_COMMIT: commit_s = 1'b1;
      default:  load_s   = 1'b0;
    endcase
  end

  // Field under conversion; a new field starts from a cleared BCD section.
  always_comb begin
    case (phase_r)
      2'd0:    field_s = snap_r[20:14];
      2'd1:    field_s = snap_r[13:7];
      2'd2:    field_s = snap_r[6:0];
      default: field_s = 7'd0;
    endcase
    if (bit_r == 3'd0) src_s = {8'd0, field_s};
    else               src_s = sh_r;
    step_out_s = dabble_step(src_s);
  end

  // Snapshot and double-dabble datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_r    <= 21'd0;
      phase_r   <= 2'd0;
      bit_r     <= 3'd0;
      sh_r      <= 15'd0;
      res_min_r <= 8'd0;
      res_sec_r <= 8'd0;
      res_per_r <= 4'd0;
    end else if (load_s) begin
      snap_r  <= clamp_s;
      phase_r <= 2'd0;
      bit_r   <= 3'd0;
    end else if (step_s) begin
      sh_r <= step_out_s;
      if (bit_r == 3'd6) begin
        bit_r   <= 3'd0;
        phase_r <= phase_r + 2'd1;
        case (phase_r)
          2'd0:    res_min_r <= step_out_s[14:7];
          2'd1:    res_sec_r <= step_out_s[14:7];
          default: res_per_r <= step_out_s[10:7];
        endcase
      end else begin
        bit_r <= bit_r + 3'd1;
      end
    end
  end

  // Committed digits change together so the display never shows a mixed value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_r <= 20'd0;
    end else if (commit_s) begin
      dig_r[0] <= res_min_r[7:4];
      dig_r[1] <= res_min_r[3:0];
      dig_r[2] <= res_sec_r[7:4];
      dig_r[3] <= res_sec_r[3:0];
      dig_r[4] <= res_per_r;
    end
  end

  // Digit scan timer and index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_r <= '0;
      idx_r      <= 3'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      idx_r      <= (idx_r == 3'd4) ? 3'd0 : idx_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Display drive straight from the index and committed digits.
  always_comb begin
    case (idx_r)
      3'd0:    cur_dig_s = dig_r[0];
      3'd1:    cur_dig_s = dig_r[1];
      3'd2:    cur_dig_s = dig_r[2];
      3'd3:    cur_dig_s = dig_r[3];
      3'd4:    cur_dig_s = dig_r[4];
      default: cur_dig_s = 4'd0;
    endcase
    an = ~(5'b00001 << idx_r);
    dp = (idx_r != 3'd1);
    if ((idx_r == 3'd0) && (cur_dig_s == 4'd0)) seg = 7'b1111111;
    else                                         seg = seg_code(cur_dig_s);
  end

  assign trig_s = ((in_prev_r[32:11] != 22'd0) && (in_q_r[32:11] == 22'd0)) ||
                  (in_q_r[10:0] > in_prev_r[10:0]);

  // Horn pulse: any trigger (re)loads the counter, so pulses extend, never stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      horn_cnt_r <= '0;
      horn_r     <= 1'b0;
    end else if (trig_s) begin
      horn_cnt_r <= HORN_LOAD;
      horn_r     <= 1'b1;
    end else if (horn_cnt_r != '0) begin
      horn_cnt_r <= horn_cnt_r - HORN_W'(1);
      horn_r     <= (horn_cnt_r > HORN_W'(1));
    end else begin
      horn_r <= 1'b0;
    end
  end

  assign horn = horn_r;

endmodule
